control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the 16-bit accumulator CPU.
- Drives the 3-bit source selector of the common-bus multiplexer and every register load, increment and clear strobe.
- Steps a timing counter through T0..T6 for the fetch, decode and execute of memory-reference and register-reference instructions.
- Sits directly upstream of the bus multiplexer; the datapath registers and RAM consume its strobes on the next rising edge.

Parameters:
- SC_W, 4: sequence-counter width. Only states T0..T6 are legal.
- IO_NOP, 1: when 1, I/O-class instructions (opcode 7, I=1) execute as a NOP at T3.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  16  current IR contents (bit 15 = I, bits 14:12 = opcode, bits 11:0 = address or register-op bits)
- ac_zero  in  1  AC == 0
- ac_sign  in  1  AC[15]
- dr_zero  in  1  DR == 0
- e_flag  in  1  E flip-flop
- bus_sel  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ir_ld, ac_ld  out  1 each  register strobes
- alu_op  out  3  0 PASS_DR, 1 AND, 2 ADD, 3 CMA, 4 SHR, 5 SHL, 6 INC, 7 CLR
- e_ld, e_clr, e_cmp  out  1 each  E-flag controls; e_ld loads the ALU carry-out
- mem_rd, mem_wr  out  1 each  RAM strobes
- sc  out  SC_W  current timing state
- halted  out  1  sticky halt flag

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On a reset edge: sc=0, halted=0, latched I=0.
  - While rst=1, all strobes and bus_sel are forced to 0 combinationally.
  - The first cycle after rst deasserts is T0.
- Output timing:
  - All strobe outputs are combinational decodes of sc, the latched I, ir and the flags. There are no extra pipeline stages.
  - Strobes not listed for a state are 0.
  - "Clr" below means sc goes to 0 on the next edge. Otherwise sc increments by 1.
- Fetch and decode:
  - T0: bus_sel=2, ar_ld.
  - T1: bus_sel=7, mem_rd, ir_ld, pc_inr.
  - T2: bus_sel=5, ar_ld (AR<-IR[11:0]). I latches ir[15] on this edge.
- T3:
  - Opcode 7, I=0: register-reference execute, then clr.
  - Opcode 7, I=1: NOP, then clr.
  - Opcode 0-6, I=1: bus_sel=7, mem_rd, ar_ld (indirect fetch).
  - Opcode 0-6, I=0: idle.
- Memory-reference instructions, T4..T6:
  - AND / ADD / LDA (opcode 0/1/2):
    - T4: bus_sel=7, mem_rd, dr_ld.
    - T5: ac_ld with alu_op AND / ADD / PASS_DR; ADD also asserts e_ld. Clr.
  - STA (3): T4: bus_sel=4, mem_wr. Clr.
  - BUN (4): T4: bus_sel=1, pc_ld. Clr.
  - BSA (5):
    - T4: bus_sel=2, mem_wr, ar_inr.
    - T5: bus_sel=1, pc_ld. Clr.
  - ISZ (6):
    - T4: bus_sel=7, mem_rd, dr_ld.
    - T5: dr_inr.
    - T6: bus_sel=3, mem_wr; pc_inr if dr_zero (sampled after the increment). Clr.
- Register-reference bits (ir[11:0], T3 only):
  - Bit map: 11 CLA, 10 CLE, 9 CMA, 8 CME, 7 CIR, 6 CIL, 5 INC, 4 SPA, 3 SNA, 2 SZA, 1 SZE, 0 HLT.
  - AC group (CLA, CMA, CIR, CIL, INC): the highest set bit selects alu_op, with ac_ld. CIR and CIL also assert e_ld.
  - E group: CLE has priority over CME.
  - Skip group: pc_inr if any selected condition is true:
    - SPA: !ac_sign
    - SNA: ac_sign
    - SZA: ac_zero
    - SZE: !e_flag
  - Groups may fire together in one cycle.
  - HLT: halted set on the edge.
- Halt:
  - While halted=1: sc frozen, all strobes 0, bus_sel=0.
  - Only rst clears halted.
- Illegal sc value (7..2^SC_W-1): all strobes 0, next sc=0.
- Reset mid-instruction: the instruction is abandoned and no strobes issue in the reset cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - bus_sel encodings (BUS_NONE..BUS_MEM)
  - opcode constants (OP_AND..OP_IOR)
  - alu_op enum
  - register-reference bit indices
- Sub-module `seq_counter`: sc register with inc / clr / hold and the illegal-state wrap. The top level holds the decode logic.

Test Plan:
- Fetch: after reset, ir=16'h2010 (LDA direct). Required: T0 bus_sel=2 ar_ld; T1 bus_sel=7 ir_ld pc_inr; T2 bus_sel=5; T4 dr_ld; T5 ac_ld with alu_op=0; sc returns to 0 on the following cycle.
- Indirect ADD, ir=16'h9020: T3 bus_sel=7 ar_ld; T5 alu_op=2 with e_ld; instruction completes in 6 cycles.
- ISZ, ir=16'h6005, dr_zero=1 at T6: bus_sel=3, mem_wr=1, pc_inr=1. Repeat with dr_zero=0: pc_inr=0.
- Register-reference, ir=16'h7221 (CMA|INC|HLT): at T3 alu_op=3 (CMA wins over INC), ac_ld=1; halted=1 afterwards; sc and strobes frozen for 20 cycles; rst then yields sc=0, halted=0.
- Skip, ir=16'h7010 (SPA), ac_sign=0: pc_inr=1 at T3. With ac_sign=1: pc_inr=0.
- Reset mid-BSA: rst asserted at T4. Required: mem_wr=0 during the reset cycle; sc=0 afterwards; the next cycle is a clean T0 fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit accumulator CPU: bus selects, opcodes,
// ALU operations, register-reference bit positions and timing states.
package cpu_pkg;

  // Common-bus source selector
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // Opcode field ir[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IOR = 3'd7;  // register-reference / I/O class

  typedef enum logic [2:0] {
    ALU_PASS_DR = 3'd0,
    ALU_AND     = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_CMA     = 3'd3,
    ALU_SHR     = 3'd4,
    ALU_SHL     = 3'd5,
    ALU_INC     = 3'd6,
    ALU_CLR     = 3'd7
  } alu_op_e;

  // Register-reference bit positions within ir[11:0]
  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  // Timing states; T_BAD stands for any counter value above T6
  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T_BAD = 3'd7
  } tstate_e;

  localparam int T_LAST = 6;

endpackage

// File: rtl/seq_counter.sv
// Timing-state counter: increments, clears or holds; any value beyond the
// last legal state returns to zero on the next edge.
module seq_counter
  import cpu_pkg::*;
#(
  parameter int SC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_hold,
  output logic [SC_W-1:0] o_sc
);

  logic [SC_W-1:0] r_sc;

  // Sequence counter register with illegal-state recovery ahead of hold
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      r_sc <= '0;
    end else if (r_sc > SC_W'(T_LAST)) begin
      r_sc <= '0;
    end else if (!i_hold) begin
      if (i_clr) r_sc <= '0;
      else       r_sc <= r_sc + SC_W'(1);
    end
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: decodes the timing state, latched indirect bit,
// IR and AC/E/DR flags into bus-select and register/RAM strobes.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int SC_W   = 4,
  parameter bit IO_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     ir,
  input  logic            ac_zero,
  input  logic            ac_sign,
  input  logic            dr_zero,
  input  logic            e_flag,
  output logic [2:0]      bus_sel,
  output logic            ar_ld,
  output logic            ar_inr,
  output logic            pc_ld,
  output logic            pc_inr,
  output logic            dr_ld,
  output logic            dr_inr,
  output logic            ir_ld,
  output logic            ac_ld,
  output logic [2:0]      alu_op,
  output logic            e_ld,
  output logic            e_clr,
  output logic            e_cmp,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [SC_W-1:0] sc,
  output logic            halted
);

  logic     r_i;
  logic     r_halted;
  logic     w_clr;
  logic     w_hlt;
  logic     w_skip;
  logic [2:0] w_op;
  tstate_e  w_t;
  alu_op_e  w_alu;

  assign w_op   = ir[14:12];
  assign w_t    = (sc <= SC_W'(T_LAST)) ? tstate_e'(sc[2:0]) : T_BAD;
  assign alu_op = w_alu;
  assign halted = r_halted;

  // Any enabled skip condition bumps PC during register-reference execute
  assign w_skip = (ir[RR_SPA] && !ac_sign) || (ir[RR_SNA] && ac_sign) ||
                  (ir[RR_SZA] && ac_zero)  || (ir[RR_SZE] && !e_flag);

  seq_counter #(.SC_W(SC_W)) u_seq_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_hold (r_halted),
    .o_sc   (sc)
  );

  // Indirect bit is captured at T2; halt is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (!r_halted && w_t == T2) r_i <= ir[15];
      if (w_hlt)                  r_halted <= 1'b1;
    end
  end

  // Strobe decode per timing state; reset and halt suppress everything
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bus_sel = BUS_NONE;
    ar_ld   = 1'b0;
    ar_inr  = 1'b0;
    pc_ld   = 1'b0;
    pc_inr  = 1'b0;
    dr_ld   = 1'b0;
    dr_inr  = 1'b0;
    ir_ld   = 1'b0;
    ac_ld   = 1'b0;
    e_ld    = 1'b0;
    e_clr   = 1'b0;
    e_cmp   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    w_alu   = ALU_PASS_DR;
    w_clr   = 1'b0;
    w_hlt   = 1'b0;

    if (!rst && !r_halted) begin
      case (w_t)
        T0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inr  = 1'b1;
        end
        T2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        T3: begin
          if (w_op == OP_IOR) begin
            if (r_i) begin
              // I/O class; with IO_NOP=0 it idles one more state and retires at T4
              w_clr = IO_NOP;
            end else begin
              w_clr = 1'b1;
              ac_ld = 1'b1;
              if      (ir[RR_CLA]) w_alu = ALU_CLR;
              else if (ir[RR_CMA]) w_alu = ALU_CMA;
              else if (ir[RR_CIR]) begin w_alu = ALU_SHR; e_ld = 1'b1; end
              else if (ir[RR_CIL]) begin w_alu = ALU_SHL; e_ld = 1'b1; end
              else if (ir[RR_INC]) w_alu = ALU_INC;
              else                 ac_ld = 1'b0;
              if      (ir[RR_CLE]) e_clr = 1'b1;
              else if (ir[RR_CME]) e_cmp = 1'b1;
              pc_inr = w_skip;
              w_hlt  = ir[RR_HLT];
            end
          end else if (r_i) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        T4: begin
          case (w_op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
              w_clr   = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              w_clr   = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              ar_inr  = 1'b1;
            end
            default: w_clr = 1'b1;
          endcase
        end
        T5: begin
          case (w_op)
            OP_AND: begin ac_ld = 1'b1; w_alu = ALU_AND;     w_clr = 1'b1; end
            OP_ADD: begin ac_ld = 1'b1; w_alu = ALU_ADD;     e_ld = 1'b1; w_clr = 1'b1; end
            OP_LDA: begin ac_ld = 1'b1; w_alu = ALU_PASS_DR; w_clr = 1'b1; end
            OP_BSA: begin bus_sel = BUS_AR; pc_ld = 1'b1;    w_clr = 1'b1; end
            OP_ISZ: dr_inr = 1'b1;
            default: w_clr = 1'b1;
          endcase
        end
        T6: begin
          w_clr = 1'b1;
          if (w_op == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inr  = dr_zero;
          end
        end
        default: ;  // illegal state: counter wraps to T0 by itself
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes the
// expected output word; a negedge monitor pops and compares it.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        ac_zero, ac_sign, dr_zero, e_flag;
  logic [2:0]  bus_sel, alu_op;
  logic        ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ir_ld, ac_ld;
  logic        e_ld, e_clr, e_cmp, mem_rd, mem_wr, halted;
  logic [3:0]  sc;

  always #5 clk = ~clk;

  control_sequencer #(.SC_W(4), .IO_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .ir(ir),
    .ac_zero(ac_zero), .ac_sign(ac_sign), .dr_zero(dr_zero), .e_flag(e_flag),
    .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld),
    .pc_inr(pc_inr), .dr_ld(dr_ld), .dr_inr(dr_inr), .ir_ld(ir_ld),
    .ac_ld(ac_ld), .alu_op(alu_op), .e_ld(e_ld), .e_clr(e_clr), .e_cmp(e_cmp),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .sc(sc), .halted(halted)
  );

  // Strobe bit masks for building expected words
  localparam logic [12:0] AR_LD  = 13'h1000, AR_INR = 13'h0800, PC_LD  = 13'h0400;
  localparam logic [12:0] PC_INR = 13'h0200, DR_LD  = 13'h0100, DR_INR = 13'h0080;
  localparam logic [12:0] IR_LD  = 13'h0040, AC_LD  = 13'h0020, E_LD   = 13'h0010;
  localparam logic [12:0] E_CLR  = 13'h0008, E_CMP  = 13'h0004, MEM_RD = 13'h0002;
  localparam logic [12:0] MEM_WR = 13'h0001, NONE   = 13'h0000;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } item_t;

  item_t sb_q[$];
  item_t cur;
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic [23:0] ex(input logic [2:0] bus, input logic [12:0] st,
                                     input logic [2:0] alu, input logic [3:0] t,
                                     input logic h);
    return {bus, st[12:5], alu, st[4:0], t, h};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
  endtask

  // Monitor: compare mid-cycle, away from the rising edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      check(cur.tag, {bus_sel, ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ir_ld,
                      ac_ld, alu_op, e_ld, e_clr, e_cmp, mem_rd, mem_wr, sc, halted},
            cur.exp);
    end
  end

  // Push the expectation for the cycle just driven, then advance one cycle
  task automatic go(input string tag, input logic [23:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] v);
    ir = v;
    go("T0", ex(3'd2, AR_LD, 3'd0, 4'd0, 1'b0));
    go("T1", ex(3'd7, MEM_RD | IR_LD | PC_INR, 3'd0, 4'd1, 1'b0));
    go("T2", ex(3'd5, AR_LD, 3'd0, 4'd2, 1'b0));
  endtask

  task automatic t3_idle(input string tag);
    go(tag, ex(3'd0, NONE, 3'd0, 4'd3, 1'b0));
  endtask

  task automatic isz(input logic z);
    fetch(16'h6005);
    t3_idle("isz_T3");
    go("isz_T4", ex(3'd7, MEM_RD | DR_LD, 3'd0, 4'd4, 1'b0));
    go("isz_T5", ex(3'd0, DR_INR, 3'd0, 4'd5, 1'b0));
    dr_zero = z;
    go("isz_T6", ex(3'd3, MEM_WR | (z ? PC_INR : NONE), 3'd0, 4'd6, 1'b0));
    dr_zero = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; ir = 16'h0000;
    ac_zero = 1'b0; ac_sign = 1'b0; dr_zero = 1'b0; e_flag = 1'b1;
    @(posedge clk);
    #1;
    go("reset", ex(3'd0, NONE, 3'd0, 4'd0, 1'b0));
    rst = 1'b0;

    // LDA direct
    fetch(16'h2010);
    t3_idle("lda_T3");
    go("lda_T4", ex(3'd7, MEM_RD | DR_LD, 3'd0, 4'd4, 1'b0));
    go("lda_T5", ex(3'd0, AC_LD, 3'd0, 4'd5, 1'b0));

    // ADD indirect
    fetch(16'h9020);
    go("add_T3", ex(3'd7, MEM_RD | AR_LD, 3'd0, 4'd3, 1'b0));
    go("add_T4", ex(3'd7, MEM_RD | DR_LD, 3'd0, 4'd4, 1'b0));
    go("add_T5", ex(3'd0, AC_LD | E_LD, 3'd2, 4'd5, 1'b0));

    // AND direct
    fetch(16'h0123);
    t3_idle("and_T3");
    go("and_T4", ex(3'd7, MEM_RD | DR_LD, 3'd0, 4'd4, 1'b0));
    go("and_T5", ex(3'd0, AC_LD, 3'd1, 4'd5, 1'b0));

    // STA, BUN, BSA
    fetch(16'h3000);
    t3_idle("sta_T3");
    go("sta_T4", ex(3'd4, MEM_WR, 3'd0, 4'd4, 1'b0));
    fetch(16'h4000);
    t3_idle("bun_T3");
    go("bun_T4", ex(3'd1, PC_LD, 3'd0, 4'd4, 1'b0));
    fetch(16'h5010);
    t3_idle("bsa_T3");
    go("bsa_T4", ex(3'd2, MEM_WR | AR_INR, 3'd0, 4'd4, 1'b0));
    go("bsa_T5", ex(3'd1, PC_LD, 3'd0, 4'd5, 1'b0));

    // ISZ with and without skip
    isz(1'b1);
    isz(1'b0);

    // Skip group
    ac_sign = 1'b0;
    fetch(16'h7010);
    go("spa_pos", ex(3'd0, PC_INR, 3'd0, 4'd3, 1'b0));
    ac_sign = 1'b1;
    fetch(16'h7010);
    go("spa_neg", ex(3'd0, NONE, 3'd0, 4'd3, 1'b0));
    ac_sign = 1'b0;
    e_flag = 1'b0;
    fetch(16'h7002);
    go("sze_e0", ex(3'd0, PC_INR, 3'd0, 4'd3, 1'b0));
    e_flag = 1'b1;

    // AC and E groups together; CIR carries e_ld
    fetch(16'h7D00);
    go("cla_cle", ex(3'd0, AC_LD | E_CLR, 3'd7, 4'd3, 1'b0));
    fetch(16'h7180);
    go("cir_cme", ex(3'd0, AC_LD | E_LD | E_CMP, 3'd4, 4'd3, 1'b0));

    // I/O class executes as NOP
    fetch(16'hF000);
    go("io_nop", ex(3'd0, NONE, 3'd0, 4'd3, 1'b0));

    // Reset in the middle of BSA
    fetch(16'h5010);
    t3_idle("bsa2_T3");
    rst = 1'b1;
    go("bsa_rst", ex(3'd0, NONE, 3'd0, 4'd4, 1'b0));
    rst = 1'b0;
    fetch(16'h2010);
    t3_idle("lda2_T3");
    go("lda2_T4", ex(3'd7, MEM_RD | DR_LD, 3'd0, 4'd4, 1'b0));
    go("lda2_T5", ex(3'd0, AC_LD, 3'd0, 4'd5, 1'b0));

    // CMA|INC|HLT, then freeze and recovery
    fetch(16'h7221);
    go("hlt_T3", ex(3'd0, AC_LD, 3'd3, 4'd3, 1'b0));
    ir = 16'h7FFF;
    for (int i = 0; i < 20; i++) go("halted", ex(3'd0, NONE, 3'd0, 4'd0, 1'b1));
    rst = 1'b1;
    go("hlt_rst", ex(3'd0, NONE, 3'd0, 4'd0, 1'b1));
    rst = 1'b0;
    fetch(16'h2010);
    t3_idle("lda3_T3");

    check("drain", 24'(sb_q.size()), 24'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
